// File: rtl/audio_cic_decimator.sv
// N-stage CIC decimator by 2**LOG2_RATE, modulo-2**W arithmetic; output registered one cycle after the R-th input.
// Input stalls (s_tready low) only while an undelivered output is held; all filter state freezes meanwhile.
module audio_cic_decimator #(
  parameter int SAMPLE_SIZE = 16,
  parameter int STAGES      = 3,
  parameter int LOG2_RATE   = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_tvalid,
  input  logic [SAMPLE_SIZE-1:0] s_tdata,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [SAMPLE_SIZE-1:0] m_tdata,
  input  logic                   m_tready
);

  localparam int SHIFT = STAGES * LOG2_RATE;
  localparam int W     = SAMPLE_SIZE + SHIFT;

  logic [W-1:0]           integ_q [STAGES];
  logic [W-1:0]           integ_d [STAGES];
  logic [W-1:0]           dly_q   [STAGES];
  logic [W-1:0]           dly_d   [STAGES];
  logic [LOG2_RATE-1:0]   phase_q, phase_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [SAMPLE_SIZE-1:0] m_tdata_q, m_tdata_d;
  logic [W-1:0]           x_ext;
  logic                   in_xfer, dec_evt;

  assign s_tready = reset_n & ~(m_tvalid_q & ~m_tready);
  assign in_xfer  = s_tvalid & s_tready;
  assign dec_evt  = in_xfer & (&phase_q);
  assign x_ext    = {{SHIFT{s_tdata[SAMPLE_SIZE-1]}}, s_tdata};
  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;

  always_comb begin
    logic [W-1:0] acc;
    logic [W-1:0] c;
    for (int k = 0; k < STAGES; k++) begin
      integ_d[k] = integ_q[k];
      dly_d[k]   = dly_q[k];
    end
    phase_d    = phase_q;
    m_tvalid_d = m_tvalid_q & ~m_tready;
    m_tdata_d  = m_tdata_q;
    acc        = x_ext;
    // Cascade all integrators within the cycle so the comb sees the freshest sum.
    for (int k = 0; k < STAGES; k++) begin
      acc = acc + integ_q[k];
      if (in_xfer) integ_d[k] = acc;
    end
    c = acc;
    for (int k = 0; k < STAGES; k++) begin
      if (dec_evt) dly_d[k] = c;
      c = c - dly_q[k];
    end
    if (in_xfer) phase_d = phase_q + LOG2_RATE'(1);
    // Top SAMPLE_SIZE bits divide by R**N, giving unity DC gain.
    if (dec_evt) begin
      m_tdata_d  = SAMPLE_SIZE'(c >> SHIFT);
      m_tvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      phase_q    <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= integ_d[k];
        dly_q[k]   <= dly_d[k];
      end
      phase_q    <= phase_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
    end
  end

endmodule

// File: tb/tb_audio_cic_decimator.sv
// Bench for audio_cic_decimator: direct-convolution reference model feeding a scoreboard queue.
// Inputs change 1 time unit after the rising edge; handshakes are observed on the falling edge.
module tb_audio_cic_decimator;

  localparam int SS = 16;
  localparam int N  = 3;
  localparam int LR = 3;
  localparam int R  = 8;
  localparam int HL = N * (R - 1) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [SS-1:0] s_tdata = '0;
  logic          s_tready;
  logic          m_tvalid;
  logic [SS-1:0] m_tdata;
  logic          m_tready = 1'b1;

  audio_cic_decimator #(.SAMPLE_SIZE(SS), .STAGES(N), .LOG2_RATE(LR)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tready (s_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tready (m_tready)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_fail = 0;
  int            h [HL];
  longint        hist [HL];
  int            nacc;
  int            n_out;
  logic [SS-1:0] sb_q [$];
  bit            lat_pend;
  bit            const_en;
  logic [SS-1:0] const_val;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: impulse response of three length-8 boxcars, exact convolution, floor-divide by 512.
  task automatic model_accept(input logic [SS-1:0] x);
    longint acc;
    for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = longint'($signed(x));
    nacc++;
    if (nacc % R == 0) begin
      acc = 0;
      for (int j = 0; j < HL; j++) acc += longint'(h[j]) * hist[j];
      acc = acc >>> (N * LR);
      sb_q.push_back(acc[SS-1:0]);
      lat_pend = 1'b1;
    end
  endtask

  task automatic cycle(input logic v, input logic [SS-1:0] d, input logic rdy);
    logic [SS-1:0] exp_v;
    s_tvalid = v;
    s_tdata  = d;
    m_tready = rdy;
    @(negedge clk);
    if (lat_pend) begin
      chk("latency_mvalid", 32'(m_tvalid), 32'd1);
      lat_pend = 1'b0;
    end
    if (m_tvalid && m_tready) begin
      if (sb_q.size() == 0) begin
        chk("spurious_output", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_v = sb_q.pop_front();
        n_out++;
        chk("out_vs_model", 32'(m_tdata), 32'(exp_v));
        if (const_en && n_out >= 3) chk("steady_value", 32'(m_tdata), 32'(const_val));
      end
    end
    if (s_tvalid && s_tready) model_accept(s_tdata);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int pending);
    chk("sb_left_at_reset", 32'(sb_q.size()), 32'(pending));
    reset_n = 1'b0;
    #1;
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_mdata", 32'(m_tdata), 32'd0);
    chk("rst_sready", 32'(s_tready), 32'd0);
    sb_q.delete();
    for (int j = 0; j < HL; j++) hist[j] = 0;
    nacc = 0;
    n_out = 0;
    lat_pend = 1'b0;
    const_en = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_const(input string tag, input logic [SS-1:0] v, input int count);
    const_en  = 1'b1;
    const_val = v;
    for (int i = 0; i < count; i++) cycle(1'b1, v, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk(tag, 32'(n_out), 32'(count / R));
    const_en = 1'b0;
  endtask

  initial begin
    int            a [HL];
    int            b [HL];
    int            len;
    int            prev;
    bit            stalled;
    logic [SS-1:0] x;

    for (int i = 0; i < HL; i++) a[i] = 0;
    a[0] = 1;
    len  = 1;
    repeat (N) begin
      for (int i = 0; i < HL; i++) b[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) b[i+j] += a[i];
      len += R - 1;
      a = b;
    end
    h = a;

    do_reset(0);
    run_const("dc_pulses", 16'd1000, 80);

    do_reset(0);
    run_const("negfs_pulses", 16'h8000, 80);

    do_reset(0);
    const_en  = 1'b1;
    const_val = 16'd0;
    for (int i = 0; i < 80; i++) cycle(1'b1, i[0] ? 16'hFC18 : 16'd1000, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk("nyq_pulses", 32'(n_out), 32'd10);
    const_en = 1'b0;

    do_reset(0);
    const_en  = 1'b1;
    const_val = 16'd1000;
    stalled   = 1'b0;
    for (int c = 0; c < 400 && nacc < 80; c++) begin
      if (!stalled && n_out == 1 && m_tvalid) begin
        stalled = 1'b1;
        repeat (20) begin
          s_tvalid = 1'b1;
          s_tdata  = 16'd1000;
          m_tready = 1'b0;
          @(negedge clk);
          chk("bp_sready_low", 32'(s_tready), 32'd0);
          chk("bp_hold_data", 32'(m_tdata), sb_q.size() > 0 ? 32'(sb_q[0]) : 32'hDEADBEEF);
          @(posedge clk);
          #1;
        end
      end
      cycle(1'b1, 16'd1000, 1'b1);
    end
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk("bp_stalled", 32'(stalled), 32'd1);
    chk("bp_pulses", 32'(n_out), 32'd10);
    const_en = 1'b0;

    do_reset(0);
    x = 16'h8123;
    for (int c = 0; c < 3000 && nacc < 160; c++) begin
      prev = nacc;
      cycle($urandom_range(0, 99) < 30, x, $urandom_range(0, 99) < 80);
      if (nacc != prev) x = x + 16'd1234;
    end
    repeat (20) cycle(1'b0, '0, 1'b1);
    chk("sparse_accepted", 32'(nacc), 32'd160);
    chk("sparse_pulses", 32'(n_out), 32'd20);

    do_reset(0);
    for (int i = 0; i < 13; i++) cycle(1'b1, 16'd1000, 1'b1);
    chk("midframe_pulses", 32'(n_out), 32'd1);
    do_reset(0);
    for (int i = 0; i < 13; i++) cycle(1'b1, 16'd1000, 1'b0);
    chk("held_accepted", 32'(nacc), 32'd8);
    do_reset(1);
    run_const("post_reset_dc_pulses", 16'd1000, 24);
    chk("sb_left_end", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
